// File: rtl/progmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : progmem_pkg
// Description : Shared types and constants for the program-memory arbiter.
//               Holds the arbiter state encoding and the default read data
//               returned on a timed-out access.
// Revision    : 1.0 - initial release
// ============================================================================
package progmem_pkg;

  // Arbiter state: idle, or memory granted to master 0 / master 1
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  // Read data handed back to a master whose access timed out
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Width of the per-grant wait counter
  localparam int unsigned WAIT_CNT_W = 8;

endpackage : progmem_pkg
`default_nettype wire

// File: rtl/progmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : progmem_arbiter
// Description : Two-master round-robin arbiter in front of a shared program
//               memory. Master 0 is the CPU, master 1 the loader/debug port.
//               Requests are forwarded combinationally while granted, the
//               memory completion is passed straight back, and a stalled
//               access is terminated after TIMEOUT cycles with ERR_DATA and a
//               sticky timeout_err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module progmem_arbiter
  import progmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  // master 0 (CPU)
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic [31:0]       m0_rdata,
  // master 1 (loader / debug)
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic [31:0]       m1_rdata,
  // shared program memory
  output logic              s_valid,
  input  logic              s_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic [31:0]       s_rdata,
  // sticky error flag
  output logic              timeout_err
);

  // Last wait-counter value before the access is abandoned
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(TIMEOUT - 1);

  state_e                state_q;
  logic                  last_grant_q;   // 0: m0 completed last, 1: m1 completed last
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic                  timeout_err_q;

  logic                  w_sel_valid;    // valid of the currently granted master
  logic                  w_done_ok;      // memory completed the granted access
  logic                  w_done_to;      // granted access abandoned on timeout

  // Round-robin pick from IDLE: a tie goes to the master not served last
  function automatic state_e rr_pick(input logic v0, input logic v1, input logic last);
    state_e pick;
    pick = IDLE;
    if (v0 && v1) begin
      pick = last ? GNT0 : GNT1;
    end else if (v0) begin
      pick = GNT0;
    end else if (v1) begin
      pick = GNT1;
    end
    return pick;
  endfunction

  // Completion conditions of the granted access; s_ready beats the timeout
  always_comb begin
    w_sel_valid = 1'b0;
    if (state_q == GNT0) begin
      w_sel_valid = m0_valid;
    end else if (state_q == GNT1) begin
      w_sel_valid = m1_valid;
    end
    w_done_ok = w_sel_valid && s_ready;
    w_done_to = w_sel_valid && !s_ready && (wait_cnt_q == WAIT_LIMIT);
  end

  // Arbiter FSM, wait counter, round-robin history and sticky error flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (w_done_to) begin
        timeout_err_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          state_q    <= rr_pick(m0_valid, m1_valid, last_grant_q);
          wait_cnt_q <= '0;
        end
        GNT0, GNT1: begin
          if (!w_sel_valid) begin
            // requester withdrew: drop the grant, keep the round-robin history
            state_q    <= IDLE;
            wait_cnt_q <= '0;
          end else if (w_done_ok || w_done_to) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            last_grant_q <= (state_q == GNT1);
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Request forwarding and completion pass-through for the granted master
  always_comb begin
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m0_ready    = 1'b0;
    m0_rdata    = '0;
    m1_ready    = 1'b0;
    m1_rdata    = '0;
    timeout_err = timeout_err_q | w_done_to;
    unique case (state_q)
      GNT0: begin
        s_valid  = m0_valid && !w_done_to;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = w_done_ok || w_done_to;
        if (w_done_ok) begin
          m0_rdata = s_rdata;
        end else if (w_done_to) begin
          m0_rdata = ERR_DATA;
        end
      end
      GNT1: begin
        s_valid  = m1_valid && !w_done_to;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = w_done_ok || w_done_to;
        if (w_done_ok) begin
          m1_rdata = s_rdata;
        end else if (w_done_to) begin
          m1_rdata = ERR_DATA;
        end
      end
      default: begin
        s_valid = 1'b0;
      end
    endcase
  end

endmodule : progmem_arbiter
`default_nettype wire

// File: doc/progmem_arbiter.md
PROGMEM_ARBITER -- requirements
Module: progmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of every address port.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles a granted access waits for s_ready (range 2..255).
REQ-003 Parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned on a timed-out access.
REQ-004 Reset is rstn, asynchronous, active-low; the clock is clk.
REQ-005 clk  input  1  clock, all state updates on the rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 m0_valid/m0_ready  input/output  1/1  CPU (PicoRV32) request and completion.
REQ-008 m0_addr/m0_wdata/m0_wstrb/m0_rdata  in/in/in/out  ADDR_W/32/4/32  CPU address, write data, byte strobes (0 = read), read data.
REQ-009 m1_valid/m1_ready/m1_addr/m1_wdata/m1_wstrb/m1_rdata  same directions and widths as m0  loader/debug requester port.
REQ-010 s_valid/s_ready  output/input  1/1  request to, and completion from, the shared program memory.
REQ-011 s_addr/s_wdata/s_wstrb/s_rdata  out/out/out/in  ADDR_W/32/4/32  forwarded request fields and memory read data.
REQ-012 timeout_err  output  1  sticky flag, set on any timed-out access.

Function
REQ-013 The FSM SHALL have states IDLE, GNT0, GNT1, driven by one registered state variable.
REQ-014 In IDLE, when exactly one mN_valid is high, the FSM SHALL go to GNTN on the next edge.
REQ-015 In IDLE, when both valids are high, the FSM SHALL grant the master not granted last (round-robin), with last_grant reset to 1 so m0 wins the first tie.
REQ-016 In GNTN, s_valid SHALL equal mN_valid, and s_addr/s_wdata/s_wstrb SHALL be driven combinationally from master N.
REQ-017 In IDLE, s_valid SHALL be 0 and s_addr/s_wdata/s_wstrb SHALL be 0.
REQ-018 In GNTN with s_ready=1, mN_ready SHALL be 1 for that cycle only, with mN_rdata=s_rdata; the FSM SHALL go to IDLE and last_grant SHALL become N.
REQ-019 The non-granted master's ready SHALL be 0 at all times, and its rdata SHALL be 0.
REQ-020 Latency: valid in IDLE at cycle T gives s_valid at T+1; s_ready at T+1+k gives mN_ready at T+1+k (k ≥ 0, pass-through, no added cycle).
REQ-021 A wait counter (8 bits) SHALL clear on entry to GNTN and increment each GNTN cycle without s_ready.
REQ-022 When the counter reaches TIMEOUT-1 without s_ready, the block SHALL do all of the following in that cycle: drive mN_ready=1 and mN_rdata=ERR_DATA, force s_valid=0, set timeout_err, and return to IDLE.
REQ-023 If s_ready and the timeout condition occur in the same cycle, s_ready SHALL win: normal completion, no error.
REQ-024 If mN_valid drops while in GNTN (protocol violation), the FSM SHALL return to IDLE next edge without asserting mN_ready and without updating last_grant.
REQ-025 s_ready seen in IDLE SHALL be ignored.
REQ-026 Back-to-back requests SHALL incur exactly one IDLE cycle between grants.
REQ-027 timeout_err SHALL clear only on reset.

Reset
REQ-028 While rstn=0, the block SHALL hold state=IDLE, last_grant=1, counter=0 and timeout_err=0.
REQ-029 While rstn=0, all outputs SHALL be 0: s_valid, m0_ready, m1_ready, rdata ports, s_addr/s_wdata/s_wstrb.
REQ-030 Reset asserted mid-transaction SHALL abandon the access with no ready pulse to any master; after release the block starts in IDLE.

Structure
REQ-031 The state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and the ERR_DATA default SHALL live in a shared package progmem_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; the round-robin pick SHALL be a local function, not a separate module.

Verification
REQ-033 Single read: m0_valid=1, addr=0x0010_0004, memory ready 1 cycle after s_valid -> s_addr=0x0010_0004 at T+1, m0_ready with rdata=mem word at T+2.
REQ-034 Contention: m0 and m1 valid together, both held, three times -> grants m0, m1, m0, each separated by one IDLE cycle.
REQ-035 Timeout: m1 read, s_ready held 0, TIMEOUT=16 -> m1_ready=1, rdata=0xDEADBEEF on the 16th GNT1 cycle, timeout_err=1 and sticky afterwards.
REQ-036 Race: s_ready=1 on the exact timeout cycle -> rdata=s_rdata, timeout_err stays 0.
REQ-037 Reset mid-grant: rstn=0 while in GNT0 with s_valid=1 -> all outputs 0 immediately (asynchronous), no m0_ready pulse, next tie after release grants m0.
REQ-038 Write pass-through: m1 wstrb=4'b0011, wdata=0x1234_5678 -> s_wstrb and s_wdata match while granted; m0 sees ready=0 throughout.
